// File: rtl/nonce_search_ctrl_pkg.sv
// Shared types, widths and helpers for the nonce search controller and its hasher.
// Word order: H0 occupies bits [255:224]; the nonce counter lives in the low word [31:0].
package nonce_search_ctrl_pkg;

    localparam int unsigned SHA256_W = 256;
    localparam int unsigned NONCE_W  = 256;
    localparam int unsigned IDX_W    = 32;
    localparam int unsigned DIFF_W   = 9;
    localparam int unsigned MAX_DIFF = 256;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_REPORT
    } search_state_t;

    // In-flight tag travelling alongside each nonce through the hasher.
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
    } tag_t;

    function automatic logic [DIFF_W-1:0] clamp_difficulty(input logic [DIFF_W-1:0] d);
        return (d > DIFF_W'(MAX_DIFF)) ? DIFF_W'(MAX_DIFF) : d;
    endfunction

    // True when the top d bits of the hash are all zero; d=0 accepts any hash.
    function automatic logic meets_difficulty(input logic [SHA256_W-1:0] hash,
                                              input logic [DIFF_W-1:0]   d);
        logic [DIFF_W-1:0] sh;
        if (d == '0) begin
            return 1'b1;
        end
        sh = DIFF_W'(SHA256_W) - d;
        return (hash >> sh) == '0;
    endfunction

    // Candidate for index idx: only the low word counts, wrapping mod 2^32.
    function automatic logic [NONCE_W-1:0] nonce_at(input logic [NONCE_W-1:0] seed,
                                                    input logic [IDX_W-1:0]   idx);
        return {seed[NONCE_W-1:IDX_W], IDX_W'(seed[IDX_W-1:0] + idx)};
    endfunction

endpackage

// File: rtl/nonce_search_ctrl_tag_pipe.sv
// Valid/index shift register that mirrors the hasher latency; DEPTH=0 is a wire.
module tag_pipe
    import nonce_search_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  tag_t tag_in,
    output tag_t tag_out_c,
    output logic empty_c
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = ^{clk, rst_n, flush};
        assign tag_out_c = tag_in;
        assign empty_c   = 1'b1;
    end else begin : g_pipe
        tag_t stage [DEPTH];

        // Flush kills every in-flight tag, including the one being shifted in.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage[i] <= '0;
                end
            end else if (flush) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage[i].valid <= 1'b0;
                end
            end else begin
                stage[0] <= tag_in;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign tag_out_c = stage[DEPTH-1];

        always_comb begin
            empty_c = 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (stage[i].valid) begin
                    empty_c = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/nonce_search_ctrl.sv
// Issues sequential nonces to the hasher and reports the lowest-index hash meeting
// the leading-zero difficulty, or exhaustion, over a valid/ready result port.
module nonce_search_ctrl
    import nonce_search_ctrl_pkg::*;
#(
    parameter int unsigned HASH_LATENCY = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [NONCE_W-1:0]  seed,
    input  logic [DIFF_W-1:0]   difficulty,
    input  logic [IDX_W-1:0]    max_count,
    output logic [NONCE_W-1:0]  hs_nonce,
    input  logic [SHA256_W-1:0] hs_hash,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_found,
    output logic [NONCE_W-1:0]  res_nonce,
    output logic [IDX_W-1:0]    res_index
);

    search_state_t      state, state_n;
    logic [NONCE_W-1:0] seed_q, seed_n;
    logic [DIFF_W-1:0]  diff_q, diff_n;
    logic [IDX_W-1:0]   max_q, max_n;
    logic               issue_vld, issue_vld_n;
    logic [IDX_W-1:0]   issue_idx, issue_idx_n;
    logic [NONCE_W-1:0] hs_nonce_n;
    logic               busy_n;
    logic               res_valid_n, res_found_n;
    logic [NONCE_W-1:0] res_nonce_n;
    logic [IDX_W-1:0]   res_index_n;

    logic flush_c;
    logic match_c;
    logic pipe_empty_c;
    tag_t tag_out_c;

    tag_pipe #(.DEPTH(HASH_LATENCY)) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_c),
        .tag_in    ({issue_vld, issue_idx}),
        .tag_out_c (tag_out_c),
        .empty_c   (pipe_empty_c)
    );

    assign match_c = tag_out_c.valid && meets_difficulty(hs_hash, diff_q);

    // Next-state and next-output logic; priority is abort > match > normal progress.
    always_comb begin
        state_n     = state;
        seed_n      = seed_q;
        diff_n      = diff_q;
        max_n       = max_q;
        issue_vld_n = issue_vld;
        issue_idx_n = issue_idx;
        hs_nonce_n  = hs_nonce;
        res_valid_n = res_valid;
        res_found_n = res_found;
        res_nonce_n = res_nonce;
        res_index_n = res_index;
        flush_c     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    seed_n      = seed;
                    diff_n      = clamp_difficulty(difficulty);
                    max_n       = max_count;
                    issue_idx_n = '0;
                    hs_nonce_n  = seed;
                    if (max_count != '0) begin
                        state_n     = S_RUN;
                        issue_vld_n = 1'b1;
                    end else begin
                        state_n     = S_REPORT;
                        res_valid_n = 1'b1;
                        res_found_n = 1'b0;
                        res_nonce_n = '0;
                        res_index_n = '0;
                    end
                end
            end
            S_RUN, S_DRAIN: begin
                if (abort) begin
                    state_n     = S_IDLE;
                    issue_vld_n = 1'b0;
                    flush_c     = 1'b1;
                end else if (match_c) begin
                    state_n     = S_REPORT;
                    issue_vld_n = 1'b0;
                    flush_c     = 1'b1;
                    res_valid_n = 1'b1;
                    res_found_n = 1'b1;
                    res_index_n = tag_out_c.index;
                    res_nonce_n = nonce_at(seed_q, tag_out_c.index);
                end else if (state == S_RUN) begin
                    if (IDX_W'(issue_idx + 1'b1) == max_q) begin
                        state_n     = S_DRAIN;
                        issue_vld_n = 1'b0;
                    end else begin
                        issue_idx_n = IDX_W'(issue_idx + 1'b1);
                        hs_nonce_n  = nonce_at(seed_q, issue_idx_n);
                    end
                end else if (pipe_empty_c) begin
                    state_n     = S_REPORT;
                    res_valid_n = 1'b1;
                    res_found_n = 1'b0;
                    res_nonce_n = '0;
                    res_index_n = max_q;
                end
            end
            S_REPORT: begin
                if (abort || res_ready) begin
                    state_n     = S_IDLE;
                    res_valid_n = 1'b0;
                    res_found_n = 1'b0;
                    res_nonce_n = '0;
                    res_index_n = '0;
                end
            end
            default: begin
                state_n     = S_IDLE;
                issue_vld_n = 1'b0;
                flush_c     = 1'b1;
                res_valid_n = 1'b0;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            seed_q    <= '0;
            diff_q    <= '0;
            max_q     <= '0;
            issue_vld <= 1'b0;
            issue_idx <= '0;
            hs_nonce  <= '0;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            res_found <= 1'b0;
            res_nonce <= '0;
            res_index <= '0;
        end else begin
            state     <= state_n;
            seed_q    <= seed_n;
            diff_q    <= diff_n;
            max_q     <= max_n;
            issue_vld <= issue_vld_n;
            issue_idx <= issue_idx_n;
            hs_nonce  <= hs_nonce_n;
            busy      <= busy_n;
            res_valid <= res_valid_n;
            res_found <= res_found_n;
            res_nonce <= res_nonce_n;
            res_index <= res_index_n;
        end
    end

endmodule

// File: doc/nonce_search_ctrl.md
# nonce_search_ctrl

Sequential driver for the SHA-256 nonce hasher. It issues candidate nonces to the hasher, one per cycle, and matches each returned hash against a leading-zero difficulty target. It reports the first, lowest-index match, or "not found", over a valid/ready result handshake. The block sits between the host/control logic and the hasher.

## Interface
Parameters:
- HASH_LATENCY, 0: cycles from `hs_nonce` driven to the matching `hs_hash`. 0 means a combinational hasher; must be ≥0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin search; sampled only in IDLE
- abort  in  1  synchronous; return to IDLE, produce no result
- seed  in  256  base nonce; sampled at accepted start
- difficulty  in  9  required leading zero bits of the hash, counted from hash[255]; values >256 are clamped to 256; sampled at start
- max_count  in  32  number of nonces to try; sampled at start
- hs_nonce  out  256  nonce to the hasher (H-word 0 in [255:224])
- hs_hash  in  256  hash from the hasher
- busy  out  1  high in any state except IDLE
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_found  out  1  1 = match, 0 = search exhausted
- res_nonce  out  256  matching nonce (0 if not found)
- res_index  out  32  match index, or max_count if not found

## Operation
- Nonce for index i: {seed[255:32], seed[31:0]+i} mod 2^32 in the low word. High words never change.
- Match rule: (hash >> (256−d)) == 0, where d is the clamped difficulty. d=0 matches any hash.
- FSM states: IDLE, RUN, DRAIN, REPORT.
  - IDLE: when start=1, latch the inputs and clear the counters.
    - If max_count≠0, go to RUN.
    - If max_count=0, go to REPORT with found=0.
  - RUN: issue index `issued`, then increment it.
    - When `issued` reaches max_count, go to DRAIN.
  - DRAIN: issue nothing. Wait until the in-flight tag pipe is empty, then go to REPORT with found=0.
  - Match in RUN or DRAIN:
    - Capture nonce, index and found=1.
    - Flush all in-flight tags; later matches are discarded.
    - Go to REPORT.
  - REPORT: hold res_* stable while res_valid=1. On res_valid&res_ready, go to IDLE.
- Tag pipe: HASH_LATENCY-deep shift register of {valid, index}.
  - Stage 0 is hs_nonce's tag when HASH_LATENCY=0.
  - The compare is qualified by the tag at the pipe output.
- Issue and retire are in order, so the first tag to match is the lowest index.
- Priority when events coincide in the same cycle:
  - abort beats a match. A match beats the RUN→DRAIN and DRAIN→REPORT transitions.
  - abort in REPORT drops the result.
  - start outside IDLE is ignored.
- Reset values: all outputs 0, hs_nonce 0, state IDLE, tag pipe cleared.
- Reset mid-search discards everything. No result is produced.

## Timing
- Start accepted at edge t: busy=1 from t+1, and index 0 is on hs_nonce during cycle t+1.
- Throughput: one nonce per cycle in RUN.
- Index i is driven in cycle t+1+i. Its hash is compared in cycle t+1+i+HASH_LATENCY.
- On a match, res_valid rises the cycle after the compare.
- Exhaustion: res_valid rises the cycle after the last tag retires. That is cycle t+2+max_count+HASH_LATENCY.
- max_count=0: res_valid at t+1.
- Result persists until accepted, with no timeout.
- After the REPORT handshake: IDLE, busy=0, res_valid=0, and a new start is accepted the next cycle.

## Structure
- Shared package holds:
  - SHA256_W=256 and NONCE_W=256.
  - The state enum `search_state_t`.
  - Function `meets_difficulty(hash, d)`.
  - The word-order convention (H0 in the MSBs), shared with the hasher.
- One sub-module, `tag_pipe`: parameterised valid/index shift register with synchronous flush. It supports depth 0 as a pass-through.

## Test plan
Bench stub hasher: hash = {32'hFFFF_FFFF − nonce[31:0], 224'hFF…F}, delayed by HASH_LATENCY cycles.
- HASH_LATENCY=0, difficulty=0, max_count=10, seed low 0x0000_0005 → res_found=1, res_index=0, low word 0x5, res_valid 2 cycles after start.
- HASH_LATENCY=3, difficulty=16, seed low 0xFFFE_FFF0, max_count=100 → res_index=16, nonce low 0xFFFF_0000. No further issue after the match; indices 17–19 in flight are discarded.
- Same as above but max_count=16 → not found, res_index=16, res_valid at t+2+16+3.
- max_count=0 → res_found=0 at t+1.
- difficulty=300 → treated as 256, exhausts.
- Seed low 0xFFFF_FFFE wraps to 0x0000_0001 by index 3.
- Hold res_ready=0 for 5 cycles: res_* stable, start pulses ignored. Then:
  - abort during RUN → IDLE next cycle, no res_valid.
  - rst_n low mid-DRAIN → all outputs 0 immediately.
